// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage register uses the slave modport; its upstream/downstream driver uses master.
interface pipe_stage_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush/stall/bubble, optional 2-entry skid buffer
// and saturating stall/flush performance counters.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             bubble,
  pipe_stage_if.slave      bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_n;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              head_v, skid_v, in_xfer, out_xfer;
  logic              head_ld_in, head_ld_skid, head_clr, skid_ld, skid_clr;

  assign head_v = (state != EMPTY);
  assign skid_v = (state == TWO);

  // reset term keeps upstream from seeing a phantom accept while the stage is held in reset
  generate
    if (SKID != 0) begin : g_skid
      assign bus.in_ready = reset & !stall & !bubble & !flush & !skid_v;
    end else begin : g_noskid
      assign bus.in_ready = reset & !stall & !bubble & !flush & (!head_v | bus.out_ready);
    end
  endgenerate

  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = head_v & bus.out_ready & !stall & !flush;
  assign bus.out_valid = head_v;
  assign bus.out_ctrl  = head_v ? head_ctrl : '0;
  assign bus.out_data  = head_data;
  assign occupancy     = state;

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    head_clr     = 1'b0;
    skid_ld      = 1'b0;
    skid_clr     = 1'b0;
    if (flush) begin
      state_n  = EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!stall) begin
      case (state)
        EMPTY: if (in_xfer) begin
          state_n    = ONE;
          head_ld_in = 1'b1;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_ld_in = 1'b1;
          end else if (in_xfer) begin
            state_n = TWO;
            skid_ld = 1'b1;
          end else if (out_xfer) begin
            state_n  = EMPTY;
            head_clr = 1'b1;
          end
        end
        TWO: if (out_xfer) begin
          state_n      = ONE;
          head_ld_skid = 1'b1;
          skid_clr     = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (head_clr) begin
        head_ctrl <= '0;
        head_data <= '0;
      end else if (head_ld_in) begin
        head_ctrl <= bus.in_ctrl;
        head_data <= bus.in_data;
      end else if (head_ld_skid) begin
        head_ctrl <= skid_ctrl;
        head_data <= skid_data;
      end
      if (skid_clr) begin
        skid_ctrl <= '0;
        skid_data <= '0;
      end else if (skid_ld) begin
        skid_ctrl <= bus.in_ctrl;
        skid_data <= bus.in_data;
      end
      // flush outranks stall, so a flushed stall cycle is not counted as a stall
      if (flush && (head_v || skid_v) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
      if (!flush && stall && head_v && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register: the next generation of the fixed per-stage latches (IF/ID, ID/EX, EX/MEM).
- Carries a generic control field and data payload with a valid/ready handshake.
- Supports flush (branch/jump squash), global freeze (cache busywait) and hazard-bubble insertion.
- Optional 2-entry skid buffer breaks the combinational ready path; saturating stall/flush counters support context-switch performance analysis.

Parameters:
- DATA_W, 96: payload width (pc, pc+4, operands, immediates, register addresses packed by the instantiating stage).
- CTRL_W, 16: control-signal width (alu_op, mux selects, mem r/w, reg write enable, branch/jump, cache-switch bits).
- SKID, 1: 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (sampled at posedge clk; 0 = reset).
- flush  in  1  squash all held entries (branch_jump_signal).
- stall  in  1  global freeze (busywait).
- bubble  in  1  hazard: refuse input this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control; zero when out_valid=0.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with stall=1 and out_valid=1, saturating.
- flush_cnt  out  CNT_W  flush events that killed at least one valid entry, saturating.

Behaviour:
- Priority per edge: reset > flush > stall > normal operation.
- Reset (reset=0 at posedge):
  - out_valid=0, out_ctrl=0, out_data=0, skid entry invalid and zero.
  - occupancy=0, stall_cnt=0, flush_cnt=0.
  - Reset in mid-operation drops all entries; no handshake completes that cycle.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready. Both are evaluated in the same cycle.
- in_ready:
  - SKID=0: in_ready = !stall & !bubble & !flush & (!out_valid | out_ready).
  - SKID=1: in_ready = !stall & !bubble & !flush & !skid_valid. Derived only from a register plus the three control inputs; no path from out_ready.
- Flush:
  - Main and skid valids cleared.
  - out_ctrl and out_data zeroed.
  - A concurrent input is dropped and out_ready is ignored.
  - flush_cnt += 1 (saturating) if any entry was valid.
  - Flush during stall still flushes.
- Stall:
  - All entries, valid bits and occupancy hold.
  - No in- or out-transfer (out_valid stays visible, but out_ready is ignored).
  - stall_cnt += 1 (saturating) if out_valid=1.
- Bubble: blocks input only. Head may still drain, so a vacated stage presents out_valid=0 and ctrl=0 next cycle, i.e. a NOP is inserted.
- State machine (SKID=1): EMPTY(0) / ONE(1) / TWO(2).
  - EMPTY: in-transfer -> ONE.
  - ONE: in-transfer without out-transfer -> TWO (new entry to skid); out-transfer without in -> EMPTY; both -> ONE (input loads head).
  - TWO: out-transfer -> ONE (skid moves to head, same edge); input impossible (in_ready=0).
  - Flush -> EMPTY from any state.
- SKID=0: states EMPTY/ONE only; simultaneous in- and out-transfer replaces the head.
- Latency: 1 cycle input->output when the stage is empty; order is strictly FIFO.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 -> out_valid=0, occupancy=0, counters 0, in_ready=0 during reset.
- Streaming (SKID=1): in_valid=1 with ctrl 0x0001..0x0005 on 5 consecutive cycles, out_ready=1 -> out_ctrl 0x0001..0x0005 on cycles 1..5, occupancy=1 throughout.
- Backpressure (SKID=1): send A, B with out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> A then B on consecutive cycles, in_ready=1 the cycle after occupancy drops to 1.
- Flush: occupancy=2, pulse flush with in_valid=1 (data C) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1. C is never emitted.
- Stall: head valid, stall=1 for 3 cycles with out_ready=1 -> head unchanged, stall_cnt=3, no transfers. Drop stall -> head emitted.
- Bubble + saturation: bubble=1 with head valid and out_ready=1 -> next cycle out_valid=0. With CNT_W=2, hold stall for 6 cycles -> stall_cnt=3.
